// File: rtl/controller_cmd_decoder_if.sv
// ============================================================================
// Module      : controller_cmd_decoder_if
// Description : Bundle of the button-code input, the drop handshake and the
//               cursor/player outputs of controller_cmd_decoder. The game side
//               (master) drives the button code and drop_ack. The decoder
//               (slave) drives the cursor, move pulse and drop request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface controller_cmd_decoder_if;
    logic [1:0] controller_state_i;  // raw asynchronous button code
    logic       drop_ack_i;          // game accepts the pending drop
    logic [2:0] cursor_o;            // selected column
    logic       move_pulse_o;        // one-cycle pulse per cursor change
    logic       drop_req_o;          // drop pending, held until acknowledged
    logic [2:0] drop_col_o;          // column of the pending drop
    logic       player_o;            // current player

    modport master (
        output controller_state_i,
        output drop_ack_i,
        input  cursor_o,
        input  move_pulse_o,
        input  drop_req_o,
        input  drop_col_o,
        input  player_o
    );

    modport slave (
        input  controller_state_i,
        input  drop_ack_i,
        output cursor_o,
        output move_pulse_o,
        output drop_req_o,
        output drop_col_o,
        output player_o
    );
endinterface

`default_nettype wire

// File: rtl/controller_cmd_decoder.sv
// ============================================================================
// Module      : controller_cmd_decoder
// Description : Turns a bouncy, asynchronous 2-bit button code into cursor
//               moves and drop requests for a column-drop game. The input is
//               synchronised, debounced by a stability filter, and fed to a
//               small IDLE/HELD/REQ state machine. Optional auto-repeat of
//               held move buttons is enabled by defining CTRL_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller_cmd_decoder #(
    parameter int STABLE_CYCLES = 250000,
    parameter int NUM_COLS      = 7,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    controller_cmd_decoder_if.slave bus
);

    // Elaboration-time guard against parameter values the logic cannot handle
    generate
        if (STABLE_CYCLES < 1 || NUM_COLS < 2 || NUM_COLS > 8 ||
            REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
            $error("controller_cmd_decoder: illegal parameter value");
        end
    endgenerate

    localparam int         CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
    localparam logic [2:0] LAST_COL  = 3'(NUM_COLS - 1);
    localparam logic [2:0] RESET_COL = 3'(NUM_COLS / 2);

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_LEFT  = 2'b10;
    localparam logic [1:0] CODE_RIGHT = 2'b01;
    localparam logic [1:0] CODE_DROP  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HELD = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;

    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       acc_q, acc_d;

    logic [1:0] state_q, state_d;
    logic [2:0] cursor_q, cursor_d;
    logic       move_q, move_d;
    logic       drop_req_q, drop_req_d;
    logic [2:0] drop_col_q, drop_col_d;
    logic       player_q, player_d;

    logic [2:0] cursor_dec, cursor_inc;
    logic       rep_fire;

    // Two-flop synchroniser; nothing downstream sees the raw input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= CODE_NONE;
            sync2_q <= CODE_NONE;
        end else begin
            sync1_q <= bus.controller_state_i;
            sync2_q <= sync1_q;
        end
    end

    // Stability filter: count how long the synchronised code has held, accept
    // it on the very edge the count reaches STABLE_CYCLES
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sync2_q == cand_q) begin
            if (cnt_q != STABLE_C) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cand_d = sync2_q;
            cnt_d  = CNT_W'(1);
        end
        acc_d = (cnt_d == STABLE_C) ? cand_d : acc_q;
    end

    // Filter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= CODE_NONE;
            cnt_q  <= '0;
            acc_q  <= CODE_NONE;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

    assign cursor_dec = (cursor_q == 3'd0) ? LAST_COL : cursor_q - 3'd1;
    assign cursor_inc = (cursor_q == LAST_COL) ? 3'd0 : cursor_q + 3'd1;

`ifdef CTRL_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_C  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] PERIOD_C = REP_W'(REPEAT_PERIOD);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;

    // Repeat timer: counts cycles in HELD with a move code; the first repeat
    // waits REPEAT_DELAY, later ones REPEAT_PERIOD; cleared outside HELD
    always_comb begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
        rep_fire    = 1'b0;
        if (state_q == S_HELD && (acc_q == CODE_LEFT || acc_q == CODE_RIGHT)) begin
            rep_cnt_d   = rep_cnt_q + 1'b1;
            rep_first_d = rep_first_q;
            if (rep_cnt_d == (rep_first_q ? DELAY_C : PERIOD_C)) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end
        end
    end

    // Repeat timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Command state machine acting on the accepted (debounced) code
    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        move_d     = 1'b0;
        drop_req_d = drop_req_q;
        drop_col_d = drop_col_q;
        player_d   = player_q;
        case (state_q)
            S_IDLE: begin
                case (acc_q)
                    CODE_LEFT: begin
                        cursor_d = cursor_dec;
                        move_d   = 1'b1;
                        state_d  = S_HELD;
                    end
                    CODE_RIGHT: begin
                        cursor_d = cursor_inc;
                        move_d   = 1'b1;
                        state_d  = S_HELD;
                    end
                    CODE_DROP: begin
                        drop_req_d = 1'b1;
                        drop_col_d = cursor_q;
                        state_d    = S_REQ;
                    end
                    default: ;
                endcase
            end
            S_HELD: begin
                // A new press only counts after the buttons return to none
                if (acc_q == CODE_NONE) begin
                    state_d = S_IDLE;
                end else if (rep_fire) begin
                    cursor_d = (acc_q == CODE_LEFT) ? cursor_dec : cursor_inc;
                    move_d   = 1'b1;
                end
            end
            S_REQ: begin
                // Cursor frozen and buttons ignored until the game takes the drop
                if (bus.drop_ack_i) begin
                    drop_req_d = 1'b0;
                    player_d   = ~player_q;
                    state_d    = S_HELD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State machine and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cursor_q   <= RESET_COL;
            move_q     <= 1'b0;
            drop_req_q <= 1'b0;
            drop_col_q <= 3'd0;
            player_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            move_q     <= move_d;
            drop_req_q <= drop_req_d;
            drop_col_q <= drop_col_d;
            player_q   <= player_d;
        end
    end

    assign bus.cursor_o     = cursor_q;
    assign bus.move_pulse_o = move_q;
    assign bus.drop_req_o   = drop_req_q;
    assign bus.drop_col_o   = drop_col_q;
    assign bus.player_o     = player_q;

endmodule

`default_nettype wire

// File: tb/tb_controller_cmd_decoder.sv
// ============================================================================
// Module      : tb_controller_cmd_decoder
// Description : Directed self-checking bench for controller_cmd_decoder with
//               short filter/repeat parameters. Expected values are worked
//               out by hand from the stimulus. Honours CTRL_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controller_cmd_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses   = 0;
    int   p0;

    controller_cmd_decoder_if bus_if ();

    controller_cmd_decoder #(
        .STABLE_CYCLES (4),
        .NUM_COLS      (7),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Count move pulses on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (bus_if.move_pulse_o === 1'b1) pulses = pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a code for 'hold' cycles, release, and let it settle back to IDLE
    task automatic press(input logic [1:0] code, input int hold);
        bus_if.controller_state_i = code;
        cyc(hold);
        bus_if.controller_state_i = 2'b00;
        cyc(12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.controller_state_i = 2'b00;
        bus_if.drop_ack_i         = 1'b0;
        rst = 1'b1;
        cyc(3);
        chk("rst_cursor",   32'(bus_if.cursor_o), 3);
        chk("rst_drop_req", 32'(bus_if.drop_req_o), 0);
        chk("rst_drop_col", 32'(bus_if.drop_col_o), 0);
        chk("rst_player",   32'(bus_if.player_o), 0);
        chk("rst_move",     32'(bus_if.move_pulse_o), 0);
        rst = 1'b0;
        cyc(2);

        // First move: exactly 7 edges after the first edge sampling 01
        p0 = pulses;
        bus_if.controller_state_i = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            if (k == 6) chk("lat_before", 32'(bus_if.cursor_o), 3);
            if (k == 7) begin
                chk("lat_cursor", 32'(bus_if.cursor_o), 4);
                chk("lat_move",   32'(bus_if.move_pulse_o), 1);
            end
        end
        cyc(1);
        chk("move_one_cycle", 32'(bus_if.move_pulse_o), 0);
        cyc(12);
        bus_if.controller_state_i = 2'b00;
        cyc(15);
        chk("hold_cursor", 32'(bus_if.cursor_o), 4);
        chk("hold_pulses", 32'(pulses - p0), 1);

        // Glitch of 3 cycles rejected, 4 cycles accepted
        p0 = pulses;
        press(2'b10, 3);
        chk("glitch_cursor", 32'(bus_if.cursor_o), 4);
        chk("glitch_pulses", 32'(pulses - p0), 0);
        press(2'b10, 4);
        chk("min_press_cursor", 32'(bus_if.cursor_o), 3);

        // drop_ack outside REQ has no effect
        bus_if.drop_ack_i = 1'b1;
        cyc(3);
        bus_if.drop_ack_i = 1'b0;
        cyc(1);
        chk("stray_ack_player", 32'(bus_if.player_o), 0);
        chk("stray_ack_cursor", 32'(bus_if.cursor_o), 3);
        chk("stray_ack_req",    32'(bus_if.drop_req_o), 0);

        // Wrap in both directions
        press(2'b01, 10);
        press(2'b01, 10);
        press(2'b01, 10);
        chk("reach_6", 32'(bus_if.cursor_o), 6);
        press(2'b01, 10);
        chk("wrap_up", 32'(bus_if.cursor_o), 0);
        press(2'b10, 10);
        chk("wrap_down", 32'(bus_if.cursor_o), 6);

        // Drop at column 2, buttons ignored while pending
        press(2'b01, 10);
        press(2'b01, 10);
        press(2'b01, 10);
        chk("reach_2", 32'(bus_if.cursor_o), 2);
        press(2'b11, 10);
        chk("drop_req", 32'(bus_if.drop_req_o), 1);
        chk("drop_col", 32'(bus_if.drop_col_o), 2);
        p0 = pulses;
        press(2'b10, 10);
        press(2'b01, 10);
        chk("req_cursor_frozen", 32'(bus_if.cursor_o), 2);
        chk("req_no_pulse",      32'(pulses - p0), 0);
        chk("req_still_high",    32'(bus_if.drop_req_o), 1);
        chk("req_col_stable",    32'(bus_if.drop_col_o), 2);
        chk("req_player",        32'(bus_if.player_o), 0);
        bus_if.drop_ack_i = 1'b1;
        cyc(1);
        bus_if.drop_ack_i = 1'b0;
        chk("ack_clears_req", 32'(bus_if.drop_req_o), 0);
        chk("ack_player",     32'(bus_if.player_o), 1);
        cyc(3);

        // Reset while a drop is pending discards it
        press(2'b11, 10);
        chk("drop2_req", 32'(bus_if.drop_req_o), 1);
        rst = 1'b1;
        cyc(1);
        chk("rst_req_drop", 32'(bus_if.drop_req_o), 0);
        chk("rst_req_plyr", 32'(bus_if.player_o), 0);
        chk("rst_req_curs", 32'(bus_if.cursor_o), 3);

        // Button held through reset release counts as a new press
        bus_if.controller_state_i = 2'b01;
        cyc(2);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            if (k == 6) chk("held_rst_before", 32'(bus_if.cursor_o), 3);
            if (k == 7) chk("held_rst_after",  32'(bus_if.cursor_o), 4);
        end
        bus_if.controller_state_i = 2'b00;
        cyc(12);

        // Long hold of 01 for 60 cycles from cursor 3
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        p0 = pulses;
        press(2'b01, 60);
        cyc(8);
`ifdef CTRL_AUTO_REPEAT_EN
        chk("long_hold_cursor", 32'(bus_if.cursor_o), 2);
        chk("long_hold_pulses", 32'(pulses - p0), 6);
`else
        chk("long_hold_cursor", 32'(bus_if.cursor_o), 4);
        chk("long_hold_pulses", 32'(pulses - p0), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/controller_cmd_decoder.md
CONTROLLER_CMD_DECODER -- requirements
Module: controller_cmd_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, 250000, consecutive clk cycles a synchronized code must hold before acceptance (must be >=1).
REQ-002 Parameter: NUM_COLS, 7, number of board columns; cursor range 0..NUM_COLS-1 (must be 2..8).
REQ-003 Parameter: REPEAT_DELAY, 25000000, cycles a move code is held before the first auto-repeat (AUTO_REPEAT_EN only).
REQ-004 Parameter: REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeats (AUTO_REPEAT_EN only).
REQ-005 Port: clk  in  1  single system clock; all logic on its rising edge.
REQ-006 Port: rst  in  1  synchronous, active-high reset.
REQ-007 Port: controller_state  in  2  asynchronous button code: 00 none, 10 left, 01 right, 11 center/drop.
REQ-008 Port: drop_ack  in  1  game FSM accepts the pending drop; sampled only in state REQ.
REQ-009 Port: cursor  out  3  currently selected column.
REQ-010 Port: move_pulse  out  1  one-cycle pulse on every cursor change.
REQ-011 Port: drop_req  out  1  drop request, held high until acknowledged.
REQ-012 Port: drop_col  out  3  column of the pending drop; valid while drop_req is high.
REQ-013 Port: player  out  1  current player; toggles on each acknowledged drop.

Function
REQ-014 controller_state SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-015 Filter SHALL hold a candidate code and a counter; while sync2 equals the candidate the counter increments (saturating); when sync2 differs, the candidate loads sync2 and the counter clears to 1.
REQ-016 The accepted code SHALL update to the candidate on the edge the counter reaches STABLE_CYCLES; a change shorter than STABLE_CYCLES cycles SHALL never be accepted.
REQ-017 FSM acts one edge after acceptance; total latency from the first edge sampling a new stable input to the cursor/drop_req update SHALL be exactly STABLE_CYCLES+3 edges.
REQ-018 FSM states SHALL be IDLE, HELD, REQ.
REQ-019 IDLE: accepted 10 -> cursor decrements, move_pulse=1, go HELD; accepted 01 -> cursor increments, move_pulse=1, go HELD; accepted 11 -> drop_req=1, drop_col=cursor, go REQ; accepted 00 -> stay.
REQ-020 Cursor SHALL wrap: decrement at 0 gives NUM_COLS-1; increment at NUM_COLS-1 gives 0.
REQ-021 HELD: stay until accepted code is 00, then go IDLE; a code change without passing through 00 (e.g. 10 to 01) SHALL NOT produce a move or drop.
REQ-022 REQ: drop_req and drop_col stable; cursor frozen; all codes ignored; on drop_ack=1 drop_req clears on the same edge, player toggles, state goes HELD.
REQ-023 drop_ack while not in REQ SHALL be ignored with no state change.
REQ-024 move_pulse SHALL be high for exactly one cycle per cursor change and low otherwise.

Reset
REQ-025 On rst=1 at an edge: sync1, sync2, candidate, accepted = 00; counters = 0; state = IDLE; cursor = NUM_COLS/2 (3 at default); player = 0; drop_req = 0; drop_col = 0; move_pulse = 0.
REQ-026 Reset during REQ SHALL drop drop_req on that edge without toggling player; the pending drop is discarded.
REQ-027 A button held through reset release SHALL be treated as a new press after STABLE_CYCLES+3 edges.

Configuration
REQ-028 Macro CTRL_AUTO_REPEAT_EN: when defined, in HELD with accepted code 10 or 01 a repeat counter runs; first extra move after REPEAT_DELAY cycles in HELD, then one move every REPEAT_PERIOD cycles, each with wrap and move_pulse; counter clears on leaving HELD.
REQ-029 Without CTRL_AUTO_REPEAT_EN: no repeat counter is instantiated; exactly one move per press; HELD waits only for release.

Verification (STABLE_CYCLES=4, NUM_COLS=7, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-030 Reset, then hold 01 for 20 cycles, release -> cursor 3->4 exactly 7 edges after first sampled 01, single move_pulse, no further change.
REQ-031 Apply 10 for 3 cycles, then 00 -> no cursor change, no move_pulse.
REQ-032 From cursor 6 press 01 -> cursor 0; from cursor 0 press 10 -> cursor 6.
REQ-033 Press 11 at cursor 2, keep drop_ack=0 for 10 cycles while pressing 10/01 -> drop_req=1, drop_col=2, cursor stays 2; drop_ack=1 -> drop_req=0 next edge, player 0->1.
REQ-034 Assert rst while drop_req=1 -> drop_req=0, player=0, cursor=3 after that edge.
REQ-035 With CTRL_AUTO_REPEAT_EN, hold 01 for 60 cycles from cursor 3 -> moves at accept, +20, +28, +36, +44, +52 cycles (cursor 3->2 after wrap sequence 4,5,6,0,1,2); without macro cursor=4.
